// File: rtl/cic_decim_comb.sv
// CIC decimator back end: decimates integrator-rate samples by R, then NUM_STAGES comb stages (M=1).
// Latency NUM_STAGES cycles from decimation capture; no backpressure, one output strobe per frame.
module cic_decim_comb #(
   parameter int ACC_WIDTH   = 20,
   parameter int NUM_STAGES  = 3,
   parameter int RATIO_WIDTH = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        valid_in,
   input  logic signed [ACC_WIDTH-1:0] comb_in,
   input  logic [RATIO_WIDTH-1:0]      dec_ratio,
   output logic signed [ACC_WIDTH-1:0] comb_out,
   output logic                        valid_out
);

   localparam logic [RATIO_WIDTH-1:0] ONE = RATIO_WIDTH'(1);

   logic                        load_q, load_d;
   logic [RATIO_WIDTH-1:0]      cnt_q, cnt_d;
   logic [RATIO_WIDTH-1:0]      r_act_q, r_act_d;
   logic signed [ACC_WIDTH-1:0] dec_q, dec_d;
   logic                        v0_q, v0_d;

   logic signed [ACC_WIDTH-1:0] d_q [NUM_STAGES];
   logic signed [ACC_WIDTH-1:0] d_d [NUM_STAGES];
   logic signed [ACC_WIDTH-1:0] y_q [NUM_STAGES];
   logic signed [ACC_WIDTH-1:0] y_d [NUM_STAGES];
   logic [NUM_STAGES-1:0]       v_q, v_d;

   logic signed [ACC_WIDTH-1:0] x_s [NUM_STAGES+1];
   logic [NUM_STAGES:0]         vs;
   logic [RATIO_WIDTH-1:0]      r_in;
   logic [RATIO_WIDTH-1:0]      r_cur;

   // Ratio 0 is treated as 1; the first cycle after reset release uses the port directly.
   always_comb begin
      r_in    = (dec_ratio == '0) ? ONE : dec_ratio;
      r_cur   = load_q ? r_in : r_act_q;
      load_d  = 1'b0;
      cnt_d   = cnt_q;
      r_act_d = load_q ? r_in : r_act_q;
      dec_d   = dec_q;
      v0_d    = 1'b0;
      if (valid_in) begin
         if (cnt_q == r_cur - ONE) begin
            dec_d   = comb_in;
            v0_d    = 1'b1;
            cnt_d   = '0;
            r_act_d = r_in;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end
   end

   always_comb begin
      x_s[0] = dec_q;
      vs[0]  = v0_q;
      for (int k = 0; k < NUM_STAGES; k++) begin
         x_s[k+1] = y_q[k];
         vs[k+1]  = v_q[k];
      end
      for (int k = 0; k < NUM_STAGES; k++) begin
         d_d[k] = d_q[k];
         y_d[k] = y_q[k];
         v_d[k] = vs[k];
         if (vs[k]) begin
            d_d[k] = x_s[k];
            y_d[k] = x_s[k] - d_q[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_q  <= 1'b1;
         cnt_q   <= '0;
         r_act_q <= ONE;
         dec_q   <= '0;
         v0_q    <= 1'b0;
         v_q     <= '0;
         for (int k = 0; k < NUM_STAGES; k++) begin
            d_q[k] <= '0;
            y_q[k] <= '0;
         end
      end else begin
         load_q  <= load_d;
         cnt_q   <= cnt_d;
         r_act_q <= r_act_d;
         dec_q   <= dec_d;
         v0_q    <= v0_d;
         v_q     <= v_d;
         for (int k = 0; k < NUM_STAGES; k++) begin
            d_q[k] <= d_d[k];
            y_q[k] <= y_d[k];
         end
      end
   end

   assign comb_out  = y_q[NUM_STAGES-1];
   assign valid_out = v_q[NUM_STAGES-1];

endmodule

// File: tb/tb_cic_decim_comb.sv
// Directed bench for cic_decim_comb: a 3-stage and a 1-stage instance share one stimulus.
module tb_cic_decim_comb;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               valid_in = 1'b0;
   logic signed [19:0] comb_in = '0;
   logic [4:0]         dec_ratio = 5'd1;
   logic signed [19:0] comb_out3, comb_out1;
   logic               valid_out3, valid_out1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cic_decim_comb #(.ACC_WIDTH(20), .NUM_STAGES(3), .RATIO_WIDTH(5)) dut3 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .comb_in(comb_in),
      .dec_ratio(dec_ratio), .comb_out(comb_out3), .valid_out(valid_out3));

   cic_decim_comb #(.ACC_WIDTH(20), .NUM_STAGES(1), .RATIO_WIDTH(5)) dut1 (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .comb_in(comb_in),
      .dec_ratio(dec_ratio), .comb_out(comb_out1), .valid_out(valid_out1));

   // Drive one cycle of input, then let the edge pass and settle.
   task automatic apply(input logic v, input logic signed [19:0] d);
      valid_in = v;
      comb_in  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [4:0] r);
      valid_in  = 1'b0;
      comb_in   = '0;
      rst_n     = 1'b0;
      dec_ratio = r;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(5'd1);
      n_cmp++;
      if (comb_out3 !== 20'sd0 || valid_out3 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: out=%0d vld=%b, want 0/0", comb_out3, valid_out3);
      end
   endtask

   task automatic test_r1_step();
      logic signed [19:0] e [5] = '{20'sd8, -20'sd16, 20'sd8, 20'sd0, 20'sd0};
      do_reset(5'd1);
      for (int i = 0; i < 8; i++) begin
         apply(1'b1, 20'sd8);
         n_cmp++;
         if (valid_out3 !== (i >= 3)) begin
            n_bad++;
            $display("FAIL r1_valid[%0d]: got %b want %b", i, valid_out3, (i >= 3));
         end
         if (i >= 3) begin
            n_cmp++;
            if (comb_out3 !== e[(i-3 < 4) ? i-3 : 4]) begin
               n_bad++;
               $display("FAIL r1_data[%0d]: got %0d want %0d", i, comb_out3, e[(i-3 < 4) ? i-3 : 4]);
            end
         end
      end
   endtask

   task automatic test_r4_ramp();
      logic signed [19:0] e [5] = '{20'sd3, -20'sd2, -20'sd1, 20'sd0, 20'sd0};
      logic signed [19:0] last;
      logic               want_v;
      last = '0;
      do_reset(5'd4);
      for (int i = 0; i < 24; i++) begin
         apply(1'b1, 20'(i));
         want_v = (i >= 6) && ((i - 6) % 4 == 0);
         n_cmp++;
         if (valid_out3 !== want_v) begin
            n_bad++;
            $display("FAIL r4_valid[%0d]: got %b want %b", i, valid_out3, want_v);
         end
         if (want_v) last = e[(i-6)/4];
         if (i >= 6) begin
            n_cmp++;
            if (comb_out3 !== last) begin
               n_bad++;
               $display("FAIL r4_data[%0d]: got %0d want %0d", i, comb_out3, last);
            end
         end
      end
   endtask

   task automatic test_wrap();
      do_reset(5'd1);
      apply(1'b1, 20'sd524287);
      apply(1'b1, -20'sd524288);
      n_cmp++;
      if (valid_out1 !== 1'b1 || comb_out1 !== 20'sd524287) begin
         n_bad++;
         $display("FAIL wrap_first: got %0d/%b want 524287/1", comb_out1, valid_out1);
      end
      apply(1'b1, -20'sd524288);
      n_cmp++;
      if (valid_out1 !== 1'b1 || comb_out1 !== 20'sd1) begin
         n_bad++;
         $display("FAIL wrap_second: got %0d/%b want 1/1", comb_out1, valid_out1);
      end
   endtask

   task automatic test_gapped();
      logic signed [19:0] e [4] = '{20'sd3, -20'sd2, -20'sd1, 20'sd0};
      logic               want_v;
      int                 s;
      s = 0;
      do_reset(5'd4);
      for (int i = 0; i < 36; i++) begin
         if (i % 2 == 0) begin
            apply(1'b1, 20'(s));
            s++;
         end else begin
            apply(1'b0, 20'sd999);
         end
         want_v = (i >= 9) && ((i - 9) % 8 == 0);
         n_cmp++;
         if (valid_out3 !== want_v) begin
            n_bad++;
            $display("FAIL gap_valid[%0d]: got %b want %b", i, valid_out3, want_v);
         end
         if (want_v) begin
            n_cmp++;
            if (comb_out3 !== e[(i-9)/8]) begin
               n_bad++;
               $display("FAIL gap_data[%0d]: got %0d want %0d", i, comb_out3, e[(i-9)/8]);
            end
         end
      end
   endtask

   task automatic test_ratio_change();
      logic signed [19:0] e [5] = '{20'sd3, -20'sd4, 20'sd1, 20'sd0, 20'sd0};
      logic               want_v;
      do_reset(5'd4);
      for (int i = 0; i < 16; i++) begin
         if (i == 2) dec_ratio = 5'd2;
         apply(1'b1, 20'(i));
         want_v = (i == 6) || (i >= 8 && i <= 14 && i % 2 == 0);
         n_cmp++;
         if (valid_out3 !== want_v) begin
            n_bad++;
            $display("FAIL ratio_valid[%0d]: got %b want %b", i, valid_out3, want_v);
         end
         if (want_v) begin
            n_cmp++;
            if (comb_out3 !== e[(i == 6) ? 0 : (i-6)/2]) begin
               n_bad++;
               $display("FAIL ratio_data[%0d]: got %0d want %0d", i, comb_out3, e[(i == 6) ? 0 : (i-6)/2]);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset(5'd1);
      for (int i = 0; i < 5; i++) apply(1'b1, 20'sd8);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (comb_out3 !== 20'sd0 || valid_out3 !== 1'b0) begin
         n_bad++;
         $display("FAIL midrst_async: got %0d/%b want 0/0", comb_out3, valid_out3);
      end
      repeat (2) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (valid_out3 !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_hold: vld=%b want 0", valid_out3);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, 20'sd5);
         n_cmp++;
         if (valid_out3 !== (i == 3)) begin
            n_bad++;
            $display("FAIL midrst_valid[%0d]: got %b want %b", i, valid_out3, (i == 3));
         end
      end
      n_cmp++;
      if (comb_out3 !== 20'sd5) begin
         n_bad++;
         $display("FAIL midrst_first: got %0d want 5", comb_out3);
      end
   endtask

   initial begin
      test_reset();
      test_r1_step();
      test_r4_ramp();
      test_wrap();
      test_gapped();
      test_ratio_change();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cic_decim_comb.md
CIC_DECIM_COMB -- requirements
Module: cic_decim_comb

Interface
REQ-001 The block SHALL take parameter ACC_WIDTH, default 20, as the width of the input, the comb stages and the output.
REQ-002 The block SHALL take parameter NUM_STAGES, default 3, as the number of cascaded comb stages (legal range 1..6).
REQ-003 The block SHALL take parameter RATIO_WIDTH, default 5, as the width of the decimation-ratio port.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 valid_in  input  1  qualifies comb_in as one integrator-rate sample for this cycle.
REQ-007 comb_in  input  ACC_WIDTH signed  sample from the last integrator stage.
REQ-008 dec_ratio  input  RATIO_WIDTH unsigned  decimation ratio R; value 0 SHALL be treated as 1.
REQ-009 comb_out  output  ACC_WIDTH signed  decimated, comb-filtered sample.
REQ-010 valid_out  output  1  one-cycle strobe marking comb_out as valid.

Function
REQ-011 A sample counter SHALL advance only on cycles with valid_in=1, and SHALL hold its value on cycles with valid_in=0.
REQ-012 When valid_in=1 and the count equals R_act-1, the block SHALL capture comb_in into the decimation register, assert the internal stage-0 valid, and clear the count to 0; R_act is the active ratio.
REQ-013 R_act SHALL be loaded from dec_ratio at reset release and at every decimation boundary (REQ-012), so a dec_ratio change mid-frame takes effect only from the next frame.
REQ-014 Comb stage k (k=1..NUM_STAGES) SHALL register y_k = x_k - d_k, where d_k is the stage input x_k from that stage's previous valid sample, differential delay M=1.
REQ-015 d_k and y_k SHALL update only on cycles where stage k's input valid is high; otherwise all stage state SHALL hold.
REQ-016 All subtraction SHALL be two's-complement modulo 2^ACC_WIDTH, with no saturation, so that integrator wrap-around cancels.
REQ-017 Latency: a sample captured at edge E SHALL appear on comb_out with valid_out=1 in the cycle after edge E+NUM_STAGES.
REQ-018 Throughput SHALL be one decimated sample per cycle, with R=1 and valid_in held high, and no bubbles or stalls.
REQ-019 valid_out SHALL be high for exactly one cycle per decimated sample, and comb_out SHALL hold its last value while valid_out=0.
REQ-020 There is no back-pressure: the downstream consumer SHALL accept every valid_out strobe.

Reset
REQ-021 rst_n=0 SHALL asynchronously clear the counter, the decimation register, all d_k and y_k, all stage valids, comb_out (to 0) and valid_out (to 0).
REQ-022 On reset assertion mid-operation, in-flight samples SHALL be discarded, and no valid_out SHALL appear until a new frame completes after release.
REQ-023 The first valid_in after reset release SHALL be counted as sample 0 of a new frame.

Verification
REQ-024 NUM_STAGES=3, R=1, comb_in=8 every cycle -> comb_out sequence 8, -16, 8, 0, 0, ... with valid_out high every cycle after 3-edge latency.
REQ-025 NUM_STAGES=3, R=4, comb_in=0,1,2,3,... every cycle -> decimated inputs 3, 7, 11, 15 -> comb_out 3, -2, -1, 0, 0, with valid_out high once per 4 inputs.
REQ-026 NUM_STAGES=1, R=1, comb_in 524287 then -524288 -> second comb_out = 1 (modular wrap), with no saturation.
REQ-027 R=4 with valid_in toggling 1,0,1,0 -> valid_out once per 4 valid samples (8 cycles), and comb_out matches the gap-free reference.
REQ-028 dec_ratio changed from 4 to 2 after 2 samples of a frame -> current frame completes at sample 4, then frames of 2 follow.
REQ-029 rst_n pulsed low while samples are in the comb pipeline -> outputs 0 immediately, no stray valid_out, and first output after release equals the first-sample response from zero state.
